// File: rtl/vp_pkg.sv
// Shared definitions for the vector issue sequencer: FSM states, opcode
// constants and MIPS instruction field positions.
package vp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } vseq_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  localparam int REG_FIELD_W    = 5;
  localparam int NUM_REG_FIELDS = 3;

  // Low bit of register field idx: 0 = rs, 1 = rt, 2 = rd
  function automatic int reg_field_lo(input int idx);
    case (idx)
      0:       return RS_LO;
      1:       return RT_LO;
      default: return RD_LO;
    endcase
  endfunction

endpackage

// File: rtl/vseq_field_off.sv
// Combinational register-field offsetter: adds the element index (mod 32)
// to rs and rt always, and to rd only for R-type instructions. Opcode,
// shamt, funct and immediate bits pass straight through.
import vp_pkg::*;

module vseq_field_off (
  input  logic [31:0] base,
  input  logic [3:0]  elem,
  input  logic [5:0]  opcode,
  output logic [31:0] instn
);

  logic       rtype;
  logic [4:0] elem_ext;

  assign rtype    = (opcode == OPC_RTYPE);
  assign elem_ext = {1'b0, elem};

  assign instn[OPC_HI:OPC_LO] = base[OPC_HI:OPC_LO];
  assign instn[RD_LO-1:0]     = base[RD_LO-1:0];

  // rs and rt are always offset; rd only for R-type (for I-type it is part
  // of the immediate and must stay untouched).
  for (genvar gi = 0; gi < NUM_REG_FIELDS; gi++) begin : g_field
    localparam int  LO         = reg_field_lo(gi);
    localparam bit  ALWAYS_OFF = (gi < 2);
    logic [4:0] sum;
    assign sum = base[LO +: REG_FIELD_W] + elem_ext;
    assign instn[LO +: REG_FIELD_W] = (ALWAYS_OFF || rtype) ? sum : base[LO +: REG_FIELD_W];
  end

endmodule

// File: rtl/vec_issue_seq.sv
// Vector instruction sequencer: accepts one vector instruction, issues one
// scalar micro-op per element with register fields offset by the element
// index, waits a fixed drain period, then pulses done.
import vp_pkg::*;

module vec_issue_seq #(
  parameter int MAX_VL    = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instn,
  input  logic [4:0]  in_vl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instn,
  output logic [3:0]  out_elem,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err_vl
);

  localparam int             DW         = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [4:0]     MAX_VL_W   = 5'(MAX_VL);
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYC);
  localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);

  vseq_state_t   state_reg, state_next;
  logic [31:0]   instn_reg, instn_next;
  logic [4:0]    vl_reg, vl_next;
  logic [3:0]    elem_reg, elem_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;

  logic          accept;
  logic          vl_over;
  logic          is_issue;
  logic          is_last;
  logic [4:0]    eff_vl;
  logic [31:0]   off_instn;

  assign is_issue = (state_reg == ISSUE);
  assign accept   = in_valid && (state_reg == IDLE);
  assign vl_over  = (in_vl > MAX_VL_W);
  assign eff_vl   = vl_over ? MAX_VL_W : in_vl;
  assign is_last  = ({1'b0, elem_reg} == (vl_reg - 5'd1));

  vseq_field_off u_field_off (
    .base   (instn_reg),
    .elem   (elem_reg),
    .opcode (instn_reg[OPC_HI:OPC_LO]),
    .instn  (off_instn)
  );

  // Outputs are gated by state so idle and reset both present zeros.
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = is_issue;
  assign out_instn = is_issue ? off_instn : 32'd0;
  assign out_elem  = is_issue ? elem_reg : 4'd0;
  assign out_last  = is_issue && is_last;
  assign done      = done_reg;
  assign err_vl    = err_reg;

  // Next-state, counter and flag logic.
  always_comb begin
    state_next = state_reg;
    instn_next = instn_reg;
    vl_next    = vl_reg;
    elem_next  = elem_reg;
    drain_next = drain_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          instn_next = in_instn;
          vl_next    = eff_vl;
          elem_next  = 4'd0;
          if (vl_over) err_next = 1'b1;
          if (eff_vl == 5'd0) done_next = 1'b1;
          else                state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (is_last) begin
            elem_next = 4'd0;
            if (DRAIN_CYC == 0) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = DRAIN;
              drain_next = DRAIN_LOAD;
            end
          end else begin
            elem_next = elem_reg + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_reg <= DRAIN_ONE) begin
          state_next = IDLE;
          drain_next = '0;
          done_next  = 1'b1;
        end else begin
          drain_next = drain_reg - DRAIN_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      instn_reg <= 32'd0;
      vl_reg    <= 5'd0;
      elem_reg  <= 4'd0;
      drain_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      instn_reg <= instn_next;
      vl_reg    <= vl_next;
      elem_reg  <= elem_next;
      drain_reg <= drain_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Directed testbench for vec_issue_seq (MAX_VL=16, DRAIN_CYC=2): a table of
// single-instruction vectors plus hand-written multi-cycle sequences.
module tb_vec_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instn;
  logic [4:0]  in_vl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instn;
  logic [3:0]  out_elem;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_vl;

  int n_cmp = 0;
  int n_bad = 0;

  vec_issue_seq #(.MAX_VL(16), .DRAIN_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instn  (in_instn),
    .in_vl     (in_vl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instn (out_instn),
    .out_elem  (out_elem),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_vl    (err_vl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instn;
    logic [4:0]  vl;
    int          stall_elem;
    int          stall_cyc;
    int          exp_uops;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_gap;
    logic        exp_err;
  } vec_t;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk(name, 64'(seen), 64'd1);
    step();
  endtask

  // Apply one table vector and check the resulting micro-op stream.
  task automatic run_vec(input vec_t v, input int idx);
    int          hs_n = 0;
    int          held = 0;
    int          stalled = 0;
    int          last_hs = 0;
    int          done_cyc = -1;
    int          first_cyc = -1;
    int          exp_held;
    bit          proto_bad = 1'b0;
    bit          have_prev = 1'b0;
    logic [1:0]  rdy_busy = 2'b00;
    logic [31:0] first_i = 32'd0;
    logic [31:0] last_i = 32'd0;
    logic [31:0] prev_i = 32'd0;
    logic [3:0]  prev_e = 4'd0;

    in_instn  = v.instn;
    in_vl     = v.vl;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        rdy_busy = {in_ready, busy};
        break;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (hs_n >= v.exp_uops) proto_bad = 1'b1;
        if (have_prev && (out_instn !== prev_i || out_elem !== prev_e)) proto_bad = 1'b1;
        if (int'(out_elem) != hs_n) proto_bad = 1'b1;
        if (out_last !== (hs_n == v.exp_uops - 1)) proto_bad = 1'b1;
        if (int'(out_elem) == v.stall_elem) held++;
        if (hs_n == 0) first_i = out_instn;
        if (int'(out_elem) == v.stall_elem && stalled < v.stall_cyc) begin
          out_ready = 1'b0;
          stalled++;
          have_prev = 1'b1;
          prev_i    = out_instn;
          prev_e    = out_elem;
        end else begin
          out_ready = 1'b1;
          have_prev = 1'b0;
          hs_n++;
          if (out_last) begin
            last_i  = out_instn;
            last_hs = cyc;
          end
        end
      end else begin
        out_ready = 1'b1;
        have_prev = 1'b0;
      end
      step();
    end
    out_ready = 1'b1;
    exp_held  = (v.exp_uops > 0) ? v.stall_cyc + 1 : 0;

    chk($sformatf("v%0d_done_seen", idx), 64'(done_cyc > 0), 64'd1);
    chk($sformatf("v%0d_uops", idx), 64'(hs_n), 64'(v.exp_uops));
    chk($sformatf("v%0d_held", idx), 64'(held), 64'(exp_held));
    chk($sformatf("v%0d_protocol", idx), 64'(proto_bad), 64'd0);
    chk($sformatf("v%0d_done_gap", idx), 64'(done_cyc - last_hs), 64'(v.exp_gap));
    chk($sformatf("v%0d_ready_busy_at_done", idx), 64'(rdy_busy), 64'b10);
    chk($sformatf("v%0d_err_vl", idx), 64'(err_vl), 64'(v.exp_err));
    if (v.exp_uops > 0) begin
      chk($sformatf("v%0d_first_latency", idx), 64'(first_cyc), 64'd1);
      chk($sformatf("v%0d_first_instn", idx), 64'(first_i), 64'(v.exp_first));
      chk($sformatf("v%0d_last_instn", idx), 64'(last_i), 64'(v.exp_last));
    end
    step();
    chk($sformatf("v%0d_done_pulse_width", idx), 64'(done), 64'd0);
    $display("vec %0d: instn=%h vl=%0d uops=%0d done_gap=%0d err_vl=%0b",
             idx, v.instn, v.vl, hs_n, done_cyc - last_hs, err_vl);
  endtask

  // Packs every output for reset-value comparison.
  function automatic logic [63:0] pack_outs();
    return {21'd0, in_ready, busy, done, err_vl, out_valid, out_last, out_elem, out_instn};
  endfunction

  localparam logic [63:0] RESET_OUTS = {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0};

  vec_t        vecs [7];
  logic [31:0] exp_b [3];
  logic        ev_valid [6];
  logic [31:0] ev_instn [6];
  logic        ev_done [6];

  initial begin
    vecs[0] = '{mk_r(2, 10, 20, 0, 6'h20), 5'd4, 0, 0, 4,
                mk_r(2, 10, 20, 0, 6'h20), mk_r(5, 13, 23, 0, 6'h20), 3, 1'b0};
    vecs[1] = '{mk_i(6'h08, 30, 31, 16'd5), 5'd3, 0, 0, 3,
                mk_i(6'h08, 30, 31, 16'd5), mk_i(6'h08, 0, 1, 16'd5), 3, 1'b0};
    vecs[2] = '{mk_r(1, 2, 30, 7, 6'h00), 5'd4, 1, 3, 4,
                mk_r(1, 2, 30, 7, 6'h00), mk_r(4, 5, 1, 7, 6'h00), 3, 1'b0};
    vecs[3] = '{mk_i(6'h23, 29, 8, 16'hfffc), 5'd20, 0, 0, 16,
                mk_i(6'h23, 29, 8, 16'hfffc), mk_i(6'h23, 12, 23, 16'hfffc), 3, 1'b1};
    vecs[4] = '{mk_r(9, 9, 9, 0, 6'h20), 5'd0, 0, 0, 0,
                32'd0, 32'd0, 1, 1'b1};
    vecs[5] = '{mk_i(6'h0d, 0, 0, 16'h1234), 5'd16, 5, 2, 16,
                mk_i(6'h0d, 0, 0, 16'h1234), mk_i(6'h0d, 15, 15, 16'h1234), 3, 1'b1};
    vecs[6] = '{mk_r(31, 31, 31, 0, 6'h25), 5'd1, 0, 0, 1,
                mk_r(31, 31, 31, 0, 6'h25), mk_r(31, 31, 31, 0, 6'h25), 3, 1'b1};

    exp_b[0] = mk_i(6'h08, 30, 31, 16'd5);
    exp_b[1] = mk_i(6'h08, 31, 0, 16'd5);
    exp_b[2] = mk_i(6'h08, 0, 1, 16'd5);

    // Back-to-back with in_valid held: A (vl=2) then B (vl=1) in the done cycle
    ev_valid[0] = 1'b1; ev_instn[0] = mk_r(6, 7, 8, 0, 6'h24);     ev_done[0] = 1'b0;
    ev_valid[1] = 1'b1; ev_instn[1] = mk_r(7, 8, 9, 0, 6'h24);     ev_done[1] = 1'b0;
    ev_valid[2] = 1'b0; ev_instn[2] = 32'd0;                       ev_done[2] = 1'b0;
    ev_valid[3] = 1'b0; ev_instn[3] = 32'd0;                       ev_done[3] = 1'b0;
    ev_valid[4] = 1'b0; ev_instn[4] = 32'd0;                       ev_done[4] = 1'b1;
    ev_valid[5] = 1'b1; ev_instn[5] = mk_i(6'h0c, 1, 2, 16'h00ff); ev_done[5] = 1'b0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instn  = 32'd0;
    in_vl     = 5'd0;
    out_ready = 1'b1;

    // Reset values while rst is held
    #3;
    chk("reset_outputs", pack_outs(), RESET_OUTS);
    step();
    step();
    rst = 1'b0;
    chk("after_release_idle", pack_outs(), RESET_OUTS);

    // addi rs=30 rt=31 imm=5 vl=3: each element checked individually
    in_instn = mk_i(6'h08, 30, 31, 16'd5);
    in_vl    = 5'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("addi_e%0d_valid", e), 64'(out_valid), 64'd1);
      chk($sformatf("addi_e%0d_instn", e), 64'(out_instn), 64'(exp_b[e]));
      chk($sformatf("addi_e%0d_last", e), 64'(out_last), 64'(e == 2));
      step();
    end
    wait_done("addi_done");

    // Table-driven single-instruction vectors
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // in_valid held high across two instructions
    in_instn = mk_r(6, 7, 8, 0, 6'h24);
    in_vl    = 5'd2;
    in_valid = 1'b1;
    step();
    in_instn = mk_i(6'h0c, 1, 2, 16'h00ff);
    in_vl    = 5'd1;
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("b2b_s%0d_valid", s), 64'(out_valid), 64'(ev_valid[s]));
      chk($sformatf("b2b_s%0d_done", s), 64'(done), 64'(ev_done[s]));
      if (ev_valid[s]) chk($sformatf("b2b_s%0d_instn", s), 64'(out_instn), 64'(ev_instn[s]));
      if (ev_done[s]) chk("b2b_ready_at_done", 64'(in_ready), 64'd1);
      if (s == 5) in_valid = 1'b0;
      step();
    end
    $display("b2b: two instructions sequenced with in_valid held");
    wait_done("b2b_second_done");

    // Reset asserted mid-issue (elem 2 of vl=8)
    in_instn = mk_r(3, 4, 5, 0, 6'h22);
    in_vl    = 5'd8;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rst_pre_elem", 64'(out_elem), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_issue_outputs", pack_outs(), RESET_OUTS);
    step();
    rst = 1'b0;
    begin
      bit spurious = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (done || out_valid) spurious = 1'b1;
        step();
      end
      chk("rst_no_done_after_abort", 64'(spurious), 64'd0);
    end
    in_instn = mk_i(6'h08, 7, 9, 16'd3);
    in_vl    = 5'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_elem0", 64'(out_elem), 64'd0);
    chk("post_rst_instn", 64'(out_instn), 64'(mk_i(6'h08, 7, 9, 16'd3)));
    $display("rst: abort mid-issue then fresh instruction from elem 0");
    wait_done("post_rst_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_issue_seq.md
VEC_ISSUE_SEQ -- requirements
Module: vec_issue_seq

Interface
REQ-001 SHALL have parameter MAX_VL, default 16, giving the maximum elements per vector instruction (range 1..16).
REQ-002 SHALL have parameter DRAIN_CYC, default 2, giving the cycles waited after the last element issues, covering EXE-to-writeback latency.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a vector instruction is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the sequencer can accept an instruction.
REQ-007 SHALL have port in_instn, input, 32 bits: MIPS-format base instruction.
REQ-008 SHALL have port in_vl, input, 5 bits: requested vector length.
REQ-009 SHALL have port out_valid, output, 1 bit: a scalar micro-op is presented to the ID stage.
REQ-010 SHALL have port out_ready, input, 1 bit: the pipeline accepts the micro-op (low means stall).
REQ-011 SHALL have port out_instn, output, 32 bits: the element micro-op.
REQ-012 SHALL have port out_elem, output, 4 bits: element index of the current micro-op.
REQ-013 SHALL have port out_last, output, 1 bit: the current micro-op is the final element.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-016 SHALL have port err_vl, output, 1 bit: sticky flag set when in_vl exceeds MAX_VL.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, DRAIN; in_ready = (state==IDLE).
REQ-018 Accept SHALL occur when in_valid && in_ready; in_instn and the effective vl are latched on that edge.
REQ-019 Effective vl SHALL be min(in_vl, MAX_VL); in_vl > MAX_VL SHALL set err_vl on the accept edge. Only reset clears err_vl.
REQ-020 Accept with vl==0 SHALL stay in IDLE, issue nothing, and assert done in the next cycle.
REQ-021 Accept with vl>=1 SHALL move to ISSUE; out_valid SHALL be high in the first ISSUE cycle, so first-issue latency is 1 cycle.
REQ-022 In ISSUE, out_valid SHALL be 1; out_instn, out_elem and out_last SHALL stay stable until out_valid && out_ready.
REQ-023 The element counter SHALL start at 0 and increment by 1 on each handshake; out_last = (elem == vl-1).
REQ-024 out_instn SHALL equal the latched instruction with register fields offset by elem: opcode==0 offsets rs, rt, rd; any other opcode offsets rs, rt only; shamt, funct and immediate pass unchanged.
REQ-025 Field offset SHALL be 5-bit modulo-32 addition; for example, base 30 + elem 3 = 1.
REQ-026 A handshake with out_last=1 SHALL move to DRAIN, load the drain counter with DRAIN_CYC, and drop out_valid in the next cycle.
REQ-027 DRAIN SHALL decrement the counter each cycle; at count 1 it SHALL go to IDLE with done=1 in the first IDLE cycle, in which in_ready is also 1.
REQ-028 If DRAIN_CYC==0, the last handshake SHALL go directly to IDLE with done asserted next cycle.
REQ-029 out_ready held low SHALL stall indefinitely without losing or duplicating elements; out_ready is ignored when out_valid=0.
REQ-030 in_valid SHALL be ignored outside IDLE, with no queuing.

Reset
REQ-031 While rst is asserted: state=IDLE, element and drain counters=0, out_valid=0, out_instn=0, out_elem=0, out_last=0, busy=0, done=0, err_vl=0, in_ready=1.
REQ-032 Reset mid-ISSUE or mid-DRAIN SHALL abort the instruction with no done pulse; operation resumes on the first clock edge after rst deasserts.

Structure
REQ-033 Shared package vp_pkg SHALL hold the state enum, OPC_RTYPE=6'h00, and the instruction field bit positions (opcode 31:26, rs 25:21, rt 20:16, rd 15:11).
REQ-034 Combinational sub-module vseq_field_off SHALL compute out_instn from the base instruction, elem and opcode; the FSM and counters stay in vec_issue_seq.

Verification
REQ-035 R-type add rs=2, rt=10, rd=20, vl=4, out_ready=1 -> 4 consecutive micro-ops (rs,rt,rd)=(2,10,20)..(5,13,23); out_last on elem 3; done exactly DRAIN_CYC+1 cycles after the last handshake.
REQ-036 I-type addi rs=30, rt=31, imm=5, vl=3 -> rs 30,31,0 and rt 31,0,1; immediate 5 unchanged in every micro-op.
REQ-037 vl=4 with out_ready low for 3 cycles during elem 1 -> elem 1 held stable 4 cycles, no skip or duplicate, 4 micro-ops total.
REQ-038 in_vl=20 -> err_vl=1 persisting through later instructions, 16 micro-ops issued; in_vl=0 -> no out_valid, done one cycle after accept.
REQ-039 rst pulsed during elem 2 of vl=8 -> all outputs at reset values immediately, no done pulse; a new instruction issued after release starts at elem 0.
REQ-040 in_valid held high across two instructions -> second accepted in the done cycle; no overlap of micro-ops between the two.
